alu_ctrl_seq: RTL and testbench

//  Registered, handshaked ALU-control stage for the pipelined/multicycle core. Decodes aluop+funct to a

---
 rtl/alu_ctrl_seq_pkg.sv | 49 ++++
 rtl/alu_ctrl_seq_funct_decode.sv | 43 ++++
 rtl/alu_ctrl_seq.sv | 99 +++++++++
 tb/tb_alu_ctrl_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared encodings for the ALU-control stage: aluop classes, R-type funct
// codes, 4-bit ALU control codes, FSM states and the decoder result struct.
package alu_ctrl_seq_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_X33  = 6'b110011;

  localparam logic [3:0] ALUCTL_AND  = 4'b0000;
  localparam logic [3:0] ALUCTL_OR   = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD  = 4'b0010;
  localparam logic [3:0] ALUCTL_NOR  = 4'b0011;
  localparam logic [3:0] ALUCTL_SLL  = 4'b0100;
  localparam logic [3:0] ALUCTL_SRL  = 4'b0101;
  localparam logic [3:0] ALUCTL_XOR  = 4'b0110;
  localparam logic [3:0] ALUCTL_SRA  = 4'b0111;
  localparam logic [3:0] ALUCTL_MULT = 4'b1000;
  localparam logic [3:0] ALUCTL_DIV  = 4'b1001;
  localparam logic [3:0] ALUCTL_SUB  = 4'b1010;
  localparam logic [3:0] ALUCTL_SLT  = 4'b1011;
  localparam logic [3:0] ALUCTL_IMM  = 4'b1101;
  localparam logic [3:0] ALUCTL_SLTU = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
    logic       is_mdu;
    logic       is_div;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_funct_decode.sv
// Combinational aluop/funct decoder. Extra R-type ops (SRL, SRA, NOR, SLTU,
// XOR) are decoded only when ALUCTRL_EXT_OPS_EN is defined; otherwise they
// fall into the illegal bucket.
module alu_ctrl_seq_funct_decode
  import alu_ctrl_seq_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Map op class (and funct for R-type) to a 4-bit control code.
  always_comb begin
    dec = '0;
    case (aluop)
      ALUOP_ADD: dec.code = ALUCTL_ADD;
      ALUOP_SUB: dec.code = ALUCTL_SUB;
      ALUOP_IMM: dec.code = ALUCTL_IMM;
      default: begin
        case (funct)
          FUNCT_SLL:  dec.code = ALUCTL_SLL;
          FUNCT_ADD:  dec.code = ALUCTL_ADD;
          FUNCT_SUB:  dec.code = ALUCTL_SUB;
          FUNCT_AND:  dec.code = ALUCTL_AND;
          FUNCT_OR:   dec.code = ALUCTL_OR;
          FUNCT_SLT:  dec.code = ALUCTL_SLT;
          FUNCT_X33:  dec.code = ALUCTL_XOR;
          FUNCT_MULT: begin dec.code = ALUCTL_MULT; dec.is_mdu = 1'b1; end
          FUNCT_DIV:  begin dec.code = ALUCTL_DIV;  dec.is_mdu = 1'b1; dec.is_div = 1'b1; end
`ifdef ALUCTRL_EXT_OPS_EN
          FUNCT_SRL:  dec.code = ALUCTL_SRL;
          FUNCT_SRA:  dec.code = ALUCTL_SRA;
          FUNCT_NOR:  dec.code = ALUCTL_NOR;
          FUNCT_SLTU: dec.code = ALUCTL_SLTU;
          FUNCT_XOR:  dec.code = ALUCTL_XOR;
`endif
          default:    dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control stage. Single-cycle ops pass through one
// register stage at full throughput; MULT/DIV hold the stage in BUSY for the
// MDU latency, then present their control word in DONE until EX takes it.
// Optional feature macro: ALUCTRL_EXT_OPS_EN (extra R-type decodes).
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              mdu_start,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             accept;

  alu_ctrl_seq_funct_decode u_dec (
    .aluop (aluop),
    .funct (funct),
    .dec   (dec)
  );

  assign ready_out = (state == ST_IDLE) && (!valid_out || ready_in) && !flush;
  assign accept    = valid_in && ready_out;
  assign busy      = (state != ST_IDLE);

  // Sequencer: output register, MDU busy counter and IDLE/BUSY/DONE state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      valid_out  <= 1'b0;
      illegal    <= 1'b0;
      mdu_start  <= 1'b0;
      alucontrol <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
      mdu_start <= 1'b0;
    end else begin
      mdu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alucontrol <= CTRL_W'(dec.code);
            illegal    <= dec.illegal;
            if (dec.is_mdu) begin
              state     <= ST_BUSY;
              cnt       <= dec.is_div ? DIV_LAST : MULT_LAST;
              mdu_start <= 1'b1;
              valid_out <= 1'b0;
            end else begin
              valid_out <= 1'b1;
            end
          end else if (ready_in) begin
            valid_out <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= ST_DONE;
            valid_out <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ready_in) begin
            state     <= ST_IDLE;
            valid_out <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with hand-computed expectations.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset_n, flush, valid_in, ready_in;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic       ready_out, valid_out, illegal, mdu_start, busy;
  logic [3:0] alucontrol;

  int total = 0;
  int bad   = 0;

  alu_ctrl_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .aluop      (aluop),
    .funct      (funct),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .mdu_start  (mdu_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] fv [5];
    logic [3:0] cv [5];
    logic [1:0] av [3];
    logic [3:0] ac [3];
    logic [3:0] ext_code;
    logic       ext_ill;
    int         n;

    fv[0] = 6'b100000; cv[0] = 4'b0010;
    fv[1] = 6'b100010; cv[1] = 4'b1010;
    fv[2] = 6'b100100; cv[2] = 4'b0000;
    fv[3] = 6'b100101; cv[3] = 4'b0001;
    fv[4] = 6'b101010; cv[4] = 4'b1011;
    av[0] = 2'b00; ac[0] = 4'b0010;
    av[1] = 2'b01; ac[1] = 4'b1010;
    av[2] = 2'b11; ac[2] = 4'b1101;
`ifdef ALUCTRL_EXT_OPS_EN
    ext_code = 4'b0111; ext_ill = 1'b0;
`else
    ext_code = 4'b0000; ext_ill = 1'b1;
`endif

    // reset state
    reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    aluop = 2'b10; funct = 6'b000000;
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mdu_start", mdu_start, 0);
    chk("rst_alucontrol", alucontrol, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", ready_out, 1);

    // single SUB then back-to-back ADD/SUB/AND/OR/SLT
    aluop = 2'b10; funct = 6'b100010; valid_in = 1'b1;
    tick();
    chk("sub_valid", valid_out, 1);
    chk("sub_code", alucontrol, 4'b1010);
    chk("sub_illegal", illegal, 0);
    for (int i = 0; i < 5; i++) begin
      funct = fv[i];
      tick();
      chk("b2b_valid", valid_out, 1);
      chk("b2b_code", alucontrol, cv[i]);
    end
    // non-R-type classes ignore funct
    funct = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      aluop = av[i];
      tick();
      chk("class_code", alucontrol, ac[i]);
      chk("class_illegal", illegal, 0);
    end
    valid_in = 1'b0; aluop = 2'b10;
    tick();
    chk("drain_valid", valid_out, 0);

    // MULT: 4-cycle busy, start pulse, output held under backpressure
    funct = 6'b011000; valid_in = 1'b1;
    #1;
    chk("mult_ready_pre", ready_out, 1);
    tick();
    valid_in = 1'b0;
    chk("mult_start", mdu_start, 1);
    chk("mult_busy", busy, 1);
    chk("mult_valid0", valid_out, 0);
    chk("mult_ready", ready_out, 0);
    tick();
    chk("mult_start_pulse", mdu_start, 0);
    tick();
    tick();
    chk("mult_valid3", valid_out, 0);
    ready_in = 1'b0;
    tick();
    chk("mult_valid4", valid_out, 1);
    chk("mult_code", alucontrol, 4'b1000);
    tick();
    tick();
    chk("mult_hold_valid", valid_out, 1);
    chk("mult_hold_code", alucontrol, 4'b1000);
    chk("mult_hold_busy", busy, 1);
    ready_in = 1'b1;
    tick();
    chk("mult_done_valid", valid_out, 0);
    chk("mult_done_busy", busy, 0);

    // illegal funct and the optional extended decode
    funct = 6'b111111; valid_in = 1'b1;
    tick();
    chk("ill_valid", valid_out, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_code", alucontrol, 0);
    funct = 6'b000011;
    tick();
    chk("sra_code", alucontrol, ext_code);
    chk("sra_illegal", illegal, ext_ill);

    // backpressure on a single-cycle op
    funct = 6'b100000;
    tick();
    chk("bp_code0", alucontrol, 4'b0010);
    ready_in = 1'b0; funct = 6'b100010;
    #1;
    chk("bp_ready", ready_out, 0);
    tick();
    tick();
    chk("bp_hold_valid", valid_out, 1);
    chk("bp_hold_code", alucontrol, 4'b0010);
    ready_in = 1'b1;
    #1;
    chk("bp_ready_release", ready_out, 1);
    tick();
    chk("bp_new_code", alucontrol, 4'b1010);
    valid_in = 1'b0;
    tick();

    // flush during DIV busy drops the same-cycle input
    funct = 6'b011010; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("div_busy", busy, 1);
    tick(); tick(); tick();
    flush = 1'b1; valid_in = 1'b1; funct = 6'b100000;
    #1;
    chk("flush_ready", ready_out, 0);
    tick();
    chk("flush_valid", valid_out, 0);
    chk("flush_busy", busy, 0);
    chk("flush_start", mdu_start, 0);
    flush = 1'b0;
    #1;
    chk("post_flush_ready", ready_out, 1);
    tick();
    chk("post_flush_valid", valid_out, 1);
    chk("post_flush_code", alucontrol, 4'b0010);
    valid_in = 1'b0;
    tick();

    // full DIV latency: valid_out exactly 32 edges after accept
    funct = 6'b011010; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    n = 0;
    while (valid_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("div_latency", n, 32);
    chk("div_code", alucontrol, 4'b1001);
    tick();
    chk("div_idle", busy, 0);

    // async reset mid-DIV busy (counter at 20)
    funct = 6'b011010; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("rst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_code", alucontrol, 0);
    chk("arst_start", mdu_start, 0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_ready", ready_out, 1);
    tick();
    chk("arst_no_start", mdu_start, 0);
    chk("arst_still_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
